gun_fire_controller: RTL and testbench
======================================

Name: gun_fire_controller

Overview:
Downstream consumer of the gun heat counter. Turns the player's held fire switch into paced bullet-spawn requests toward the bullet/projectile stage. Stamps each request with muzzle coordinates derived from the ship position. Locks out firing when the heat level reaches the overheat threshold and releases the lockout with hysteresis.

Parameters:
FIRE_INTERVAL, 12_500_000, reload cycles between accepted shots (4 shots/s at 50 MHz); must be >= 1; benches use 4
RELOAD_WIDTH, 24, width of the reload counter; must hold FIRE_INTERVAL-1
OVERHEAT_LEVEL, 15, heat value at or above which firing locks out
RECOVER_LEVEL, 4, heat value at or below which the lockout may clear; must be < OVERHEAT_LEVEL
MUZZLE_X_OFFSET, 2, added to ship_x for the bullet origin
MUZZLE_Y_OFFSET, 1, subtracted from ship_y for the bullet origin

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-low reset; 0 sampled at a posedge clock resets the block
shoot  in  1  fire switch, level; holding it gives auto-fire
heat  in  4  current gun heat level from the cooldown counter, 0..15
ship_x  in  8  ship column, 0..159
ship_y  in  7  ship row, 0..119
bullet_ack  in  1  spawn stage accepted the current request
fire_req  out  1  spawn request, held until acknowledged
bullet_x  out  8  muzzle column, stable while fire_req=1
bullet_y  out  7  muzzle row, stable while fire_req=1
overheated  out  1  1 while in lockout
shot_count  out  8  accepted shots, wraps 255->0

Behaviour:
- All state updates on posedge clock. reset has priority over everything.
- Reset values: state IDLE, fire_req=0, bullet_x=0, bullet_y=0, overheated=0, shot_count=0, reload counter=0.
- States: IDLE, REQ, RELOAD, OVERHEAT. Outputs are registered.
- IDLE:
  - If heat>=OVERHEAT_LEVEL, go to OVERHEAT and set overheated=1 on the next cycle. This check takes priority over shoot.
  - Else if shoot=1, capture bullet_x=min(ship_x+MUZZLE_X_OFFSET, 159) and bullet_y=max(ship_y-MUZZLE_Y_OFFSET, 0). Compute both at 9 bits to avoid wrap. Set fire_req=1 and go to REQ.
  - bullet_ack in IDLE is ignored.
- REQ:
  - fire_req stays 1 and the coordinates stay frozen. ship_x and ship_y changes are ignored.
  - On bullet_ack=1: set fire_req=0, increment shot_count, load the reload counter with FIRE_INTERVAL-1, go to RELOAD.
  - With no ack, wait indefinitely.
  - A heat rise or a shoot release during REQ does not cancel the pending request.
- RELOAD:
  - The counter decrements each cycle while nonzero.
  - When in RELOAD with counter=0: if heat>=OVERHEAT_LEVEL go to OVERHEAT, else go to IDLE.
  - shoot is ignored in this state.
- OVERHEAT:
  - overheated=1 and fire_req=0.
  - Exit to IDLE only when heat<=RECOVER_LEVEL and shoot=0 in the same cycle; overheated=0 on the next cycle.
  - Holding shoot keeps the lock on even when heat is low.
- Latency:
  - shoot sampled in IDLE at edge N gives fire_req=1 after edge N.
  - With ack in the first REQ cycle, consecutive fire_req rises are exactly FIRE_INTERVAL+2 cycles apart.
- Reset mid-operation drops fire_req in the same edge. No ack is owed afterward.

Decomposition:
- Shared package starflux_pkg holds:
  - SCREEN_X_MAX=159 and SCREEN_Y_MAX=119
  - coordinate widths (8/7) and HEAT_WIDTH=4
  - the gun_state_t enum {IDLE, REQ, RELOAD, OVERHEAT}
- One sub-module is natural: fire_reload_timer (load value, decrement, zero flag, parameter RELOAD_WIDTH). The FSM and coordinate logic live in the top.

Test Plan:
- Reset to idle: hold reset=0 for 3 cycles with shoot=1 and heat=0, then release -> after reset all outputs are 0; fire_req rises 1 cycle after release.
- Fire pacing: FIRE_INTERVAL=4, shoot held, heat=0, ack same cycle as request -> fire_req rises every 6 cycles; shot_count 1,2,3 after three acks; shot_count wraps 255->0 after 256 acks.
- Coordinate clamp: ship_x=158, ship_y=0 -> bullet_x=159, bullet_y=0. Change ship_x to 10 during REQ with ack delayed 5 cycles -> bullet_x stays 159 until the ack.
- Overheat lockout: heat=15 in IDLE with shoot=1 -> OVERHEAT, overheated=1, no fire_req. Heat lowered to 5 -> stays locked. Heat 4 with shoot=1 -> stays locked. Release shoot -> IDLE the next cycle.
- Heat during REQ: heat jumps to 15 while fire_req=1 -> request still completes on ack; after reload expiry goes to OVERHEAT, not IDLE.
- Reset mid-request: fire_req=1 with no ack, apply reset=0 -> fire_req=0 after that edge; a late bullet_ack pulse after reset is ignored and shot_count stays 0.

Source files
------------

// File: rtl/starflux_pkg.sv
// starflux_pkg: definitions shared by the starflux gun blocks.
//   - screen limits (SCREEN_X_MAX, SCREEN_Y_MAX)
//   - coordinate widths (X_WIDTH, Y_WIDTH) and HEAT_WIDTH
//   - gun_state_t, the gun fire controller state encoding
//   - muzzle coordinate clamp helpers working on 9-bit intermediates
package starflux_pkg;

    localparam int SCREEN_X_MAX = 159;
    localparam int SCREEN_Y_MAX = 119;
    localparam int X_WIDTH      = 8;
    localparam int Y_WIDTH      = 7;
    localparam int HEAT_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        RELOAD   = 2'd2,
        OVERHEAT = 2'd3
    } gun_state_t;

    // Clamp a 9-bit column sum to the right screen edge.
    function automatic logic [X_WIDTH-1:0] clamp_x(input logic [8:0] v);
        if (v > 9'(SCREEN_X_MAX)) begin
            return X_WIDTH'(SCREEN_X_MAX);
        end
        return v[X_WIDTH-1:0];
    endfunction

    // Clamp a 9-bit row difference. A subtraction below zero wraps to a
    // value with bit 8 set, which maps to the top row.
    function automatic logic [Y_WIDTH-1:0] clamp_y(input logic [8:0] v);
        if (v[8]) begin
            return '0;
        end
        if (v > 9'(SCREEN_Y_MAX)) begin
            return Y_WIDTH'(SCREEN_Y_MAX);
        end
        return v[Y_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/gun_fire_controller_if.sv
// gun_fire_controller_if: bullet spawn request channel.
//   fire_req   : request from the fire controller
//   bullet_x   : muzzle column of the requested bullet
//   bullet_y   : muzzle row of the requested bullet
//   bullet_ack : spawn stage accepts the current request
//
// Handshake: fire_req is raised with bullet_x/bullet_y valid and is held,
// with the coordinates frozen, until a cycle where fire_req=1 and
// bullet_ack=1 at the same posedge; that edge completes the transfer and
// fire_req drops on it. bullet_ack sampled while fire_req=0 has no effect.
interface gun_fire_controller_if;
    import starflux_pkg::*;

    logic               fire_req;
    logic [X_WIDTH-1:0] bullet_x;
    logic [Y_WIDTH-1:0] bullet_y;
    logic               bullet_ack;

    modport master (
        output fire_req,
        output bullet_x,
        output bullet_y,
        input  bullet_ack
    );

    modport slave (
        input  fire_req,
        input  bullet_x,
        input  bullet_y,
        output bullet_ack
    );

endinterface

// File: rtl/fire_reload_timer.sv
// fire_reload_timer: down-counter pacing shots after each accepted request.
//   clock      : system clock
//   reset      : synchronous active-low reset, clears the count
//   load       : load load_value this cycle (priority over decrement)
//   load_value : reload count
//   zero       : count is zero
// The count decrements each cycle while nonzero and holds at zero.
module fire_reload_timer #(
    parameter int RELOAD_WIDTH = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [RELOAD_WIDTH-1:0] load_value,
    output logic                    zero
);

    logic [RELOAD_WIDTH-1:0] count_q;
    logic [RELOAD_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - RELOAD_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/gun_fire_controller.sv
// gun_fire_controller: turns the held fire switch into paced bullet spawn
// requests stamped with muzzle coordinates, with heat lockout.
//   clock, reset : system clock, synchronous active-low reset
//   shoot        : fire switch level (held = auto-fire)
//   heat         : gun heat level 0..15
//   ship_x/ship_y: ship position
//   spawn        : request channel (fire_req, bullet_x, bullet_y, bullet_ack)
//   overheated   : 1 while locked out
//   shot_count   : accepted shots, wrapping
//   state_dbg    : current controller state
module gun_fire_controller
    import starflux_pkg::*;
#(
    parameter int FIRE_INTERVAL   = 12_500_000,
    parameter int RELOAD_WIDTH    = 24,
    parameter int OVERHEAT_LEVEL  = 15,
    parameter int RECOVER_LEVEL   = 4,
    parameter int MUZZLE_X_OFFSET = 2,
    parameter int MUZZLE_Y_OFFSET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  shoot,
    input  logic [HEAT_WIDTH-1:0] heat,
    input  logic [X_WIDTH-1:0]    ship_x,
    input  logic [Y_WIDTH-1:0]    ship_y,
    gun_fire_controller_if.master spawn,
    output logic                  overheated,
    output logic [7:0]            shot_count,
    output gun_state_t            state_dbg
);

    localparam logic [HEAT_WIDTH-1:0]   HOT_LEVEL  = HEAT_WIDTH'(OVERHEAT_LEVEL);
    localparam logic [HEAT_WIDTH-1:0]   COOL_LEVEL = HEAT_WIDTH'(RECOVER_LEVEL);
    localparam logic [RELOAD_WIDTH-1:0] RELOAD_LD  = RELOAD_WIDTH'(FIRE_INTERVAL - 1);

    gun_state_t         state_q, state_d;
    logic               fire_req_q, fire_req_d;
    logic [X_WIDTH-1:0] bullet_x_q, bullet_x_d;
    logic [Y_WIDTH-1:0] bullet_y_q, bullet_y_d;
    logic               overheated_q, overheated_d;
    logic [7:0]         shot_count_q, shot_count_d;

    logic               timer_load;
    logic               timer_zero;
    logic               too_hot;
    logic               cooled;
    logic [8:0]         muzzle_x9;
    logic [8:0]         muzzle_y9;

    fire_reload_timer #(
        .RELOAD_WIDTH (RELOAD_WIDTH)
    ) u_reload (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (RELOAD_LD),
        .zero       (timer_zero)
    );

    assign too_hot = (heat >= HOT_LEVEL);
    assign cooled  = (heat <= COOL_LEVEL);

    // 9-bit arithmetic so the edge cases clamp instead of wrapping.
    assign muzzle_x9 = {1'b0, ship_x} + 9'(MUZZLE_X_OFFSET);
    assign muzzle_y9 = {2'b00, ship_y} - 9'(MUZZLE_Y_OFFSET);

    always_comb begin
        state_d      = state_q;
        fire_req_d   = fire_req_q;
        bullet_x_d   = bullet_x_q;
        bullet_y_d   = bullet_y_q;
        overheated_d = overheated_q;
        shot_count_d = shot_count_q;
        timer_load   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Heat check wins over a pending trigger pull.
                if (too_hot) begin
                    state_d      = OVERHEAT;
                    overheated_d = 1'b1;
                end else if (shoot) begin
                    bullet_x_d = clamp_x(muzzle_x9);
                    bullet_y_d = clamp_y(muzzle_y9);
                    fire_req_d = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // Once raised, the request completes regardless of heat or
                // shoot; only the ack moves us on.
                if (spawn.bullet_ack) begin
                    fire_req_d   = 1'b0;
                    shot_count_d = shot_count_q + 8'd1;
                    timer_load   = 1'b1;
                    state_d      = RELOAD;
                end
            end
            RELOAD: begin
                if (timer_zero) begin
                    if (too_hot) begin
                        state_d      = OVERHEAT;
                        overheated_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OVERHEAT: begin
                // Hysteresis: leave only once cool and the trigger is let go.
                fire_req_d = 1'b0;
                if (cooled && !shoot) begin
                    state_d      = IDLE;
                    overheated_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                fire_req_d   = 1'b0;
                overheated_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            fire_req_q   <= 1'b0;
            bullet_x_q   <= '0;
            bullet_y_q   <= '0;
            overheated_q <= 1'b0;
            shot_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            fire_req_q   <= fire_req_d;
            bullet_x_q   <= bullet_x_d;
            bullet_y_q   <= bullet_y_d;
            overheated_q <= overheated_d;
            shot_count_q <= shot_count_d;
        end
    end

    assign spawn.fire_req = fire_req_q;
    assign spawn.bullet_x = bullet_x_q;
    assign spawn.bullet_y = bullet_y_q;
    assign overheated     = overheated_q;
    assign shot_count     = shot_count_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_gun_fire_controller.sv
module tb_gun_fire_controller;
    import starflux_pkg::*;

    localparam int FI = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // ---------------- DUT ----------------
    logic                  shoot = 1'b0;
    logic [HEAT_WIDTH-1:0] heat = '0;
    logic [X_WIDTH-1:0]    ship_x = '0;
    logic [Y_WIDTH-1:0]    ship_y = '0;
    logic                  overheated;
    logic [7:0]            shot_count;
    gun_state_t            state_dbg;

    gun_fire_controller_if spawn_if ();

    gun_fire_controller #(
        .FIRE_INTERVAL   (FI),
        .RELOAD_WIDTH    (24),
        .OVERHEAT_LEVEL  (15),
        .RECOVER_LEVEL   (4),
        .MUZZLE_X_OFFSET (2),
        .MUZZLE_Y_OFFSET (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .shoot      (shoot),
        .heat       (heat),
        .ship_x     (ship_x),
        .ship_y     (ship_y),
        .spawn      (spawn_if),
        .overheated (overheated),
        .shot_count (shot_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    // ---------------- ack driver ----------------
    // auto_ack answers every request in its first cycle; man_ack gives a
    // single pulse sampled on the following posedge.
    logic auto_ack = 1'b0;
    logic man_ack  = 1'b0;
    always @(negedge clock) spawn_if.bullet_ack = (auto_ack & spawn_if.fire_req) | man_ack;

    // ---------------- scoreboard ----------------
    logic [14:0] exp_q[$];
    int          rise_cyc[$];
    logic        req_prev = 1'b0;

    always @(negedge clock) begin
        if (spawn_if.fire_req && !req_prev) begin
            rise_cyc.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_req: got x=%0d y=%0d, required no request",
                         spawn_if.bullet_x, spawn_if.bullet_y);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                if ({spawn_if.bullet_x, spawn_if.bullet_y} !== e) begin
                    n_err++;
                    $display("FAIL req_coords: got x=%0d y=%0d, required x=%0d y=%0d",
                             spawn_if.bullet_x, spawn_if.bullet_y, e[14:7], e[6:0]);
                end
            end
        end
        req_prev = spawn_if.fire_req;
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int x, input int y);
        exp_q.push_back({8'(x), 7'(y)});
    endtask

    task automatic wait_req(input string name, input int budget);
        int n;
        n = 0;
        while (!spawn_if.fire_req && n < budget) begin
            tick(1);
            n++;
        end
        check(name, int'(spawn_if.fire_req), 1);
    endtask

    task automatic wait_count(input string name, input int val, input int budget);
        int n;
        n = 0;
        while (int'(shot_count) != val && n < budget) begin
            tick(1);
            n++;
        end
        check(name, int'(shot_count), val);
    endtask

    task automatic ack_pulse();
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        spawn_if.bullet_ack = 1'b0;

        // Reset held 3 cycles with shoot already high.
        shoot  = 1'b1;
        heat   = 4'd0;
        ship_x = 8'd20;
        ship_y = 7'd50;
        push_exp(22, 49);
        tick(3);
        check("rst_fire_req", int'(spawn_if.fire_req), 0);
        check("rst_bullet_x", int'(spawn_if.bullet_x), 0);
        check("rst_bullet_y", int'(spawn_if.bullet_y), 0);
        check("rst_overheated", int'(overheated), 0);
        check("rst_shot_count", int'(shot_count), 0);
        check("rst_state", int'(state_dbg), int'(IDLE));
        reset = 1'b1;
        tick(1);
        check("first_req_latency", int'(spawn_if.fire_req), 1);

        // Auto-fire pacing: three shots, ack in the first REQ cycle.
        push_exp(22, 49);
        push_exp(22, 49);
        auto_ack = 1'b1;
        wait_count("pace_count1", 1, 10);
        wait_count("pace_count2", 2, 10);
        wait_count("pace_count3", 3, 10);
        shoot = 1'b0;
        tick(8);
        check("pace_rises", rise_cyc.size(), 3);
        if (rise_cyc.size() >= 3) begin
            check("pace_gap1", rise_cyc[1] - rise_cyc[0], FI + 2);
            check("pace_gap2", rise_cyc[2] - rise_cyc[1], FI + 2);
        end

        // Shot counter wrap: 253 more shots takes it 3 -> 255 -> 0.
        for (int i = 0; i < 253; i++) push_exp(22, 49);
        shoot = 1'b1;
        wait_count("wrap_255", 255, 2000);
        wait_count("wrap_0", 0, 20);
        shoot    = 1'b0;
        auto_ack = 1'b0;
        tick(8);
        check("wrap_idle", int'(state_dbg), int'(IDLE));

        // Coordinate clamp and freeze while the ack is delayed.
        ship_x = 8'd158;
        ship_y = 7'd0;
        push_exp(159, 0);
        shoot = 1'b1;
        wait_req("clamp_req", 5);
        ship_x = 8'd10;
        shoot  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("clamp_hold_x", int'(spawn_if.bullet_x), 159);
            check("clamp_hold_req", int'(spawn_if.fire_req), 1);
        end
        ack_pulse();
        check("clamp_ack_drop", int'(spawn_if.fire_req), 0);
        check("clamp_count", int'(shot_count), 1);
        tick(8);

        // Overheat lockout and hysteresis.
        heat  = 4'd15;
        shoot = 1'b1;
        tick(1);
        check("oh_state", int'(state_dbg), int'(OVERHEAT));
        tick(1);
        check("oh_flag", int'(overheated), 1);
        check("oh_no_req", int'(spawn_if.fire_req), 0);
        heat = 4'd5;
        shoot = 1'b0;
        tick(3);
        check("oh_heat5", int'(overheated), 1);
        heat  = 4'd4;
        shoot = 1'b1;
        tick(3);
        check("oh_heat4_shoot", int'(overheated), 1);
        shoot = 1'b0;
        tick(1);
        check("oh_release_state", int'(state_dbg), int'(IDLE));
        check("oh_release_flag", int'(overheated), 0);
        heat = 4'd0;
        tick(2);

        // Heat spike while a request is pending.
        ship_x = 8'd100;
        ship_y = 7'd119;
        push_exp(102, 118);
        shoot = 1'b1;
        wait_req("hot_req", 5);
        heat  = 4'd15;
        shoot = 1'b0;
        tick(2);
        check("hot_req_held", int'(spawn_if.fire_req), 1);
        ack_pulse();
        check("hot_ack_drop", int'(spawn_if.fire_req), 0);
        check("hot_reload", int'(state_dbg), int'(RELOAD));
        begin
            int n;
            int saw_idle;
            n = 0;
            saw_idle = 0;
            while (state_dbg != OVERHEAT && n < 10) begin
                tick(1);
                if (state_dbg == IDLE) saw_idle = 1;
                n++;
            end
            check("hot_to_overheat", int'(state_dbg), int'(OVERHEAT));
            check("hot_skip_idle", saw_idle, 0);
        end
        tick(1);
        check("hot_flag", int'(overheated), 1);
        heat = 4'd0;
        tick(2);
        check("hot_recover", int'(state_dbg), int'(IDLE));
        check("hot_count", int'(shot_count), 2);

        // Reset in the middle of a pending request.
        ship_x = 8'd40;
        ship_y = 7'd30;
        push_exp(42, 29);
        shoot = 1'b1;
        wait_req("mid_req", 5);
        shoot = 1'b0;
        reset = 1'b0;
        tick(1);
        check("mid_rst_req", int'(spawn_if.fire_req), 0);
        check("mid_rst_count", int'(shot_count), 0);
        check("mid_rst_state", int'(state_dbg), int'(IDLE));
        reset = 1'b1;
        tick(1);
        ack_pulse();
        tick(2);
        check("late_ack_count", int'(shot_count), 0);
        check("late_ack_req", int'(spawn_if.fire_req), 0);

        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
